mult_scheduler: RTL and testbench

Shares one fixed-latency pipelined signed multiplier (32-bit operands, 5-bit tag, LATENCY-cycle tag/result pipe, no stall) between NUM_REQ requesters. Arbitrates round-robin, registers operands into the multiplier and tracks in-flight slots with its own valid/requester-id shift pipe. Buffers results in a credit-guarded FIFO so a stalled writeback never loses a product. Sits between the issue stage(s) and the register-file writeback port.

---
 rtl/mult_sched_pkg.sv | 14 +
 rtl/mult_result_fifo.sv | 56 +++++
 rtl/mult_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_mult_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared constants and the result FIFO entry for the multiplier scheduler.
package mult_sched_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEF_TAG_W = 5;
    localparam int unsigned ID_W      = 2;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [DEF_TAG_W-1:0] tag;
        logic [ID_W-1:0]      req_id;
    } fifo_entry_t;

endpackage

// File: rtl/mult_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count.
module mult_result_fifo
    import mult_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  fifo_entry_t       push_data,
    input  logic              pop,
    output fifo_entry_t       head_c,
    output logic              valid_c,
    output logic [CNT_W-1:0]  count
);

    fifo_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop_en;

    assign valid_c = (count != '0);
    assign head_c  = mem[rd_ptr];
    assign pop_en  = pop && valid_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Upstream credit accounting must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && !pop_en && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin issue of NUM_REQ requesters onto one pipelined multiplier with credit-guarded result FIFO.
// Optional tag-hazard scoreboard: define MULT_SCHED_SCOREBOARD_EN.
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_W      = DEF_TAG_W
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [DATA_W*NUM_REQ-1:0] req_op1,
    input  logic [DATA_W*NUM_REQ-1:0] req_op2,
    input  logic [TAG_W*NUM_REQ-1:0]  req_tag,
    output logic [DATA_W-1:0]         mul_op1,
    output logic [DATA_W-1:0]         mul_op2,
    output logic [TAG_W-1:0]          mul_tag_in,
    input  logic [DATA_W-1:0]         mul_out,
    input  logic [TAG_W-1:0]          mul_tag_out,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [DATA_W-1:0]         wb_data,
    output logic [TAG_W-1:0]          wb_tag,
    output logic [ID_W-1:0]           wb_req_id,
    output logic                      err_tag_mismatch
);

    localparam int unsigned RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(FIFO_DEPTH + LATENCY + 2);

    logic [RR_W-1:0]    rr_ptr;
    logic               s0_valid;
    logic [ID_W-1:0]    s0_id;
    logic [LATENCY-1:0] v_pipe;
    logic [ID_W-1:0]    id_pipe  [LATENCY];
    logic [TAG_W-1:0]   tag_pipe [LATENCY];

    logic [NUM_REQ-1:0] blocked;
    logic [NUM_REQ-1:0] eligible;
    logic               any_elig;
    logic               fwd_found;
    logic [RR_W-1:0]    fwd_idx;
    logic [RR_W-1:0]    wrap_idx;
    logic [RR_W-1:0]    grant_idx;
    logic               accept;
    logic [DATA_W-1:0]  sel_op1;
    logic [DATA_W-1:0]  sel_op2;
    logic [TAG_W-1:0]   sel_tag;
    logic [OUT_W-1:0]   outstanding;
    logic               credit_ok;

    logic               push;
    logic               pop;
    fifo_entry_t        push_entry;
    fifo_entry_t        fifo_head_c;
    logic               fifo_valid_c;
    logic [CNT_W-1:0]   fifo_count;

    // Every slot from S0 through the FIFO holds one unit of credit.
    always_comb begin
        outstanding = OUT_W'(fifo_count) + OUT_W'(s0_valid);
        for (int i = 0; i < int'(LATENCY); i++) begin
            outstanding = outstanding + OUT_W'(v_pipe[i]);
        end
    end

    assign credit_ok = (outstanding < OUT_W'(FIFO_DEPTH));

`ifdef MULT_SCHED_SCOREBOARD_EN
    logic [(1 << TAG_W)-1:0] busy;

    always_comb begin
        blocked = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            blocked[i] = busy[req_tag[TAG_W*i +: TAG_W]];
        end
    end

    // Tag 0 is a don't-care destination and never reserved.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            if (pop) begin
                busy[wb_tag] <= 1'b0;
            end
            if (accept && (sel_tag != '0)) begin
                busy[sel_tag] <= 1'b1;
            end
        end
    end
`else
    assign blocked = '0;
`endif

    // Round robin: lowest eligible index at/after rr_ptr, else lowest overall.
    always_comb begin
        eligible  = req_valid & ~blocked;
        any_elig  = 1'b0;
        fwd_found = 1'b0;
        fwd_idx   = '0;
        wrap_idx  = '0;
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
            if (eligible[j]) begin
                any_elig = 1'b1;
                wrap_idx = RR_W'(j);
                if (RR_W'(j) >= rr_ptr) begin
                    fwd_found = 1'b1;
                    fwd_idx   = RR_W'(j);
                end
            end
        end
        grant_idx = fwd_found ? fwd_idx : wrap_idx;
        accept    = any_elig && credit_ok;
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
        sel_op1 = '0;
        sel_op2 = '0;
        sel_tag = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (RR_W'(i) == grant_idx) begin
                sel_op1 = req_op1[DATA_W*i +: DATA_W];
                sel_op2 = req_op2[DATA_W*i +: DATA_W];
                sel_tag = req_tag[TAG_W*i +: TAG_W];
            end
        end
    end

    // S0: operand registers feeding the multiplier.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= '0;
            s0_valid   <= 1'b0;
            s0_id      <= '0;
            mul_op1    <= '0;
            mul_op2    <= '0;
            mul_tag_in <= '0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                rr_ptr     <= (grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                s0_id      <= ID_W'(grant_idx);
                mul_op1    <= sel_op1;
                mul_op2    <= sel_op2;
                mul_tag_in <= sel_tag;
            end
        end
    end

    // In-flight tracking, aligned so the last stage matches mul_out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_pipe <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                id_pipe[i]  <= '0;
                tag_pipe[i] <= '0;
            end
        end else begin
            v_pipe[0]   <= s0_valid;
            id_pipe[0]  <= s0_id;
            tag_pipe[0] <= mul_tag_in;
            for (int i = 1; i < int'(LATENCY); i++) begin
                v_pipe[i]   <= v_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign push = v_pipe[LATENCY-1];
    assign pop  = fifo_valid_c && wb_ready;

    always_comb begin
        push_entry        = '0;
        push_entry.data   = mul_out;
        push_entry.tag    = DEF_TAG_W'(tag_pipe[LATENCY-1]);
        push_entry.req_id = id_pipe[LATENCY-1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_tag_mismatch <= 1'b0;
        end else if (push && (mul_tag_out != tag_pipe[LATENCY-1])) begin
            err_tag_mismatch <= 1'b1;
        end
    end

    mult_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_c    (fifo_head_c),
        .valid_c   (fifo_valid_c),
        .count     (fifo_count)
    );

    assign wb_valid  = fifo_valid_c;
    assign wb_data   = fifo_head_c.data;
    assign wb_tag    = TAG_W'(fifo_head_c.tag);
    assign wb_req_id = fifo_head_c.req_id;

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler with a behavioural signed 16x16 pipelined multiplier.
module tb_mult_scheduler;
    import mult_sched_pkg::*;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned LATENCY    = 3;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TAG_W      = 5;

    logic                      clock = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W*NUM_REQ-1:0] req_op1;
    logic [DATA_W*NUM_REQ-1:0] req_op2;
    logic [TAG_W*NUM_REQ-1:0]  req_tag;
    logic [DATA_W-1:0]         mul_op1;
    logic [DATA_W-1:0]         mul_op2;
    logic [TAG_W-1:0]          mul_tag_in;
    logic [DATA_W-1:0]         mul_out;
    logic [TAG_W-1:0]          mul_tag_out;
    logic                      wb_valid;
    logic                      wb_ready;
    logic [DATA_W-1:0]         wb_data;
    logic [TAG_W-1:0]          wb_tag;
    logic [ID_W-1:0]           wb_req_id;
    logic                      err_tag_mismatch;

    logic                      corrupt = 1'b0;
    logic [31:0]               mp_data [LATENCY];
    logic [TAG_W-1:0]          mp_tag  [LATENCY];

    int                        n_cmp = 0;
    int                        n_err = 0;
    fifo_entry_t               exp_q[$];

    always #5 clock = ~clock;

    mult_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op1          (req_op1),
        .req_op2          (req_op2),
        .req_tag          (req_tag),
        .mul_op1          (mul_op1),
        .mul_op2          (mul_op2),
        .mul_tag_in       (mul_tag_in),
        .mul_out          (mul_out),
        .mul_tag_out      (mul_tag_out),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_data          (wb_data),
        .wb_tag           (wb_tag),
        .wb_req_id        (wb_req_id),
        .err_tag_mismatch (err_tag_mismatch)
    );

    // Multiplier: not reset, so stale products keep flowing after a scheduler reset.
    always @(posedge clock) begin
        mp_data[0] <= $signed({{16{mul_op1[15]}}, mul_op1[15:0]}) * $signed({{16{mul_op2[15]}}, mul_op2[15:0]});
        mp_tag[0]  <= mul_tag_in;
        for (int i = 1; i < int'(LATENCY); i++) begin
            mp_data[i] <= mp_data[i-1];
            mp_tag[i]  <= mp_tag[i-1];
        end
    end
    assign mul_out     = mp_data[LATENCY-1];
    assign mul_tag_out = mp_tag[LATENCY-1] ^ {{(TAG_W-1){1'b0}}, corrupt};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] t);
        req_valid[r]             = v;
        req_op1[32*r +: 32]      = a;
        req_op2[32*r +: 32]      = b;
        req_tag[TAG_W*r +: TAG_W] = t;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_op1   = '0;
        req_op2   = '0;
        req_tag   = '0;
        wb_ready  = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic expect_wb(input logic [31:0] d, input logic [TAG_W-1:0] t, input logic [ID_W-1:0] id);
        fifo_entry_t e;
        e.data   = d;
        e.tag    = t;
        e.req_id = id;
        exp_q.push_back(e);
    endtask

    // Called at a negedge: a visible wb_valid & wb_ready pops at the next edge.
    task automatic collect();
        fifo_entry_t e;
        if (wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("wb_extra", {31'b0, wb_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wb_data", wb_data, e.data);
                check_eq("wb_tag", 32'(wb_tag), 32'(e.tag));
                check_eq("wb_req_id", 32'(wb_req_id), 32'(e.req_id));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NUM_REQ-1:0] rdy_exp [1:16];
        logic [NUM_REQ-1:0] r1_on   [1:16];
        int lat;

        // Single request and reset values.
        do_reset();
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_wb_tag", 32'(wb_tag), 32'd0);
        check_eq("rst_wb_req_id", 32'(wb_req_id), 32'd0);
        check_eq("rst_mul_op1", mul_op1, 32'd0);
        check_eq("rst_mul_op2", mul_op2, 32'd0);
        check_eq("rst_mul_tag_in", 32'(mul_tag_in), 32'd0);
        check_eq("rst_err", 32'(err_tag_mismatch), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        set_req(0, 1'b1, 32'd3, 32'hFFFF_FFFB, 5'd7);
        #1 check_eq("single_ready", 32'(req_ready), 32'b01);
        @(negedge clock);
        req_valid = '0;
        check_eq("single_mul_op1", mul_op1, 32'd3);
        check_eq("single_mul_op2", mul_op2, 32'hFFFF_FFFB);
        check_eq("single_mul_tag", 32'(mul_tag_in), 32'd7);
        lat = 1;
        while (!wb_valid && lat < 12) begin
            @(negedge clock);
            lat++;
        end
        check_eq("single_latency", 32'(lat), 32'd5);
        check_eq("single_data", wb_data, 32'hFFFF_FFF1);
        check_eq("single_tag", 32'(wb_tag), 32'd7);
        check_eq("single_id", 32'(wb_req_id), 32'd0);
        check_eq("single_err", 32'(err_tag_mismatch), 32'd0);
        wb_ready = 1'b1;
        @(negedge clock);
        wb_ready = 1'b0;
        check_eq("single_popped", 32'(wb_valid), 32'd0);

        // Round robin with both requesters always valid; credit inserts two bubbles.
        do_reset();
        rdy_exp[1] = 2'b01; rdy_exp[2] = 2'b10; rdy_exp[3] = 2'b01; rdy_exp[4]  = 2'b10;
        rdy_exp[5] = 2'b00; rdy_exp[6] = 2'b00; rdy_exp[7] = 2'b01; rdy_exp[8]  = 2'b10;
        rdy_exp[9] = 2'b01; rdy_exp[10] = 2'b10;
        expect_wb(32'd2, 5'd1, 2'd0);            expect_wb(32'hFFFF_FFFA, 5'd18, 2'd1);
        expect_wb(32'd6, 5'd3, 2'd0);            expect_wb(32'hFFFF_FFF4, 5'd20, 2'd1);
        expect_wb(32'd14, 5'd7, 2'd0);           expect_wb(32'hFFFF_FFE8, 5'd24, 2'd1);
        expect_wb(32'd18, 5'd9, 2'd0);           expect_wb(32'hFFFF_FFE2, 5'd26, 2'd1);
        for (int k = 1; k <= 20; k++) begin
            wb_ready = 1'b1;
            collect();
            if (k <= 10) begin
                set_req(0, 1'b1, 32'(k), 32'd2, 5'(k));
                set_req(1, 1'b1, 32'(k), 32'hFFFF_FFFD, 5'(k + 16));
                #1 check_eq($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(rdy_exp[k]));
            end else begin
                req_valid = '0;
            end
            @(negedge clock);
        end
        check_eq("rr_missing", 32'(exp_q.size()), 32'd0);

        // Backpressure: four credits, then resume when writeback drains.
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            rdy_exp[k] = (k <= 4 || k >= 12) ? 2'b01 : 2'b00;
        end
        expect_wb(32'd1, 5'd17, 2'd0);   expect_wb(32'd4, 5'd18, 2'd0);
        expect_wb(32'd9, 5'd19, 2'd0);   expect_wb(32'd16, 5'd20, 2'd0);
        expect_wb(32'd144, 5'd28, 2'd0); expect_wb(32'd169, 5'd29, 2'd0);
        expect_wb(32'd196, 5'd30, 2'd0); expect_wb(32'd225, 5'd31, 2'd0);
        for (int k = 1; k <= 24; k++) begin
            wb_ready = (k >= 11);
            collect();
            if (k <= 15) begin
                set_req(0, 1'b1, 32'(k), 32'(k), 5'(k + 16));
                #1 check_eq($sformatf("bp_ready_%0d", k), 32'(req_ready), 32'(rdy_exp[k]));
                if (k == 10) check_eq("bp_full_valid", 32'(wb_valid), 32'd1);
            end else begin
                req_valid = '0;
            end
            @(negedge clock);
        end
        check_eq("bp_missing", 32'(exp_q.size()), 32'd0);

        // Reset two cycles after an accept discards the in-flight product.
        do_reset();
        wb_ready = 1'b1;
        set_req(0, 1'b1, 32'd7, 32'd6, 5'd3);
        #1 check_eq("mid_ready", 32'(req_ready), 32'b01);
        @(negedge clock);
        req_valid = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("mid_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("mid_mul_op1", mul_op1, 32'd0);
        check_eq("mid_mul_tag", 32'(mul_tag_in), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("mid_quiet_%0d", k), 32'(wb_valid), 32'd0);
            @(negedge clock);
        end
        check_eq("mid_err", 32'(err_tag_mismatch), 32'd0);

        // Corrupted multiplier tag: sticky error, FIFO keeps the expected tag.
        do_reset();
        corrupt = 1'b1;
        set_req(1, 1'b1, 32'd5, 32'hFFFF_FFFC, 5'd12);
        #1 check_eq("tagerr_ready", 32'(req_ready), 32'b10);
        @(negedge clock);
        req_valid = '0;
        repeat (5) @(negedge clock);
        check_eq("tagerr_valid", 32'(wb_valid), 32'd1);
        check_eq("tagerr_data", wb_data, 32'hFFFF_FFEC);
        check_eq("tagerr_tag", 32'(wb_tag), 32'd12);
        check_eq("tagerr_id", 32'(wb_req_id), 32'd1);
        check_eq("tagerr_err", 32'(err_tag_mismatch), 32'd1);
        repeat (2) @(negedge clock);
        check_eq("tagerr_sticky", 32'(err_tag_mismatch), 32'd1);
        corrupt = 1'b0;
        do_reset();
        check_eq("tagerr_cleared", 32'(err_tag_mismatch), 32'd0);

        // Duplicate destination tag 9 from the second requester.
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            rdy_exp[k] = 2'b00;
            r1_on[k]   = 2'b00;
        end
        rdy_exp[1] = 2'b01;
`ifdef MULT_SCHED_SCOREBOARD_EN
        for (int k = 2; k <= 8; k++) r1_on[k] = 2'b10;
        rdy_exp[8] = 2'b10;
`else
        r1_on[2]   = 2'b10;
        rdy_exp[2] = 2'b10;
`endif
        expect_wb(32'd6, 5'd9, 2'd0);
        expect_wb(32'd20, 5'd9, 2'd1);
        for (int k = 1; k <= 16; k++) begin
            wb_ready = (k >= 7);
            collect();
            set_req(0, (k == 1), 32'd2, 32'd3, 5'd9);
            set_req(1, r1_on[k][1], 32'd4, 32'd5, 5'd9);
            if (k <= 8) begin
                #1 check_eq($sformatf("sb_ready_%0d", k), 32'(req_ready), 32'(rdy_exp[k]));
            end
            @(negedge clock);
        end
        check_eq("sb_missing", 32'(exp_q.size()), 32'd0);
        check_eq("final_err", 32'(err_tag_mismatch), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
